// File: rtl/cmp_sched.sv
// Two-requester scheduler for one shared signed A>B comparator. Builds the
// relations GT/LT/GE/LE/EQ/NE from one or two comparator passes.
module cmp_sched #(
   parameter int WIDTH   = 32,
   parameter int CMP_LAT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_result,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_result,
   output logic [WIDTH-1:0] cmp_a,
   output logic [WIDTH-1:0] cmp_b,
   input  logic [WIDTH-1:0] cmp_g
);

   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // Responses hold valid and result stable until ready is seen.

   typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;

   localparam logic [2:0] OP_LT = 3'd1;
   localparam logic [2:0] OP_GE = 3'd2;
   localparam logic [2:0] OP_LE = 3'd3;
   localparam logic [2:0] OP_EQ = 3'd4;
   localparam logic [2:0] OP_NE = 3'd5;
   localparam logic [1:0] CNT_LAST = 2'(CMP_LAT - 1);

   state_t           state;
   logic             rr_ptr;
   logic             winner;
   logic             grant;
   logic             accept;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [2:0]       op_q;
   logic [1:0]       cnt;
   logic             g1;
   logic             res;
   logic             g;
   logic             cmp_g_unused;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [2:0]       sel_op;
   logic             sel_swap;
   logic             two_pass;
   logic             invert;

   assign g            = cmp_g[0];
   assign cmp_g_unused = ^cmp_g[WIDTH-1:1];

   // With only one requester valid it wins; rr_ptr breaks ties.
   always_comb begin
      grant = rr_ptr;
      if (req0_valid && !req1_valid)
         grant = 1'b0;
      else if (req1_valid && !req0_valid)
         grant = 1'b1;
   end

   assign accept     = (state == IDLE) && (req0_valid || req1_valid);
   assign req0_ready = (state == IDLE) && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && req1_valid && grant;

   assign sel_a    = grant ? req1_a  : req0_a;
   assign sel_b    = grant ? req1_b  : req0_b;
   assign sel_op   = grant ? req1_op : req0_op;
   assign sel_swap = (sel_op == OP_LT) || (sel_op == OP_GE);
   assign two_pass = (op_q == OP_EQ) || (op_q == OP_NE);
   assign invert   = (op_q == OP_GE) || (op_q == OP_LE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= 1'b0;
         winner      <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         cnt         <= '0;
         g1          <= 1'b0;
         res         <= 1'b0;
         cmp_a       <= '0;
         cmp_b       <= '0;
         rsp0_valid  <= 1'b0;
         rsp0_result <= '0;
         rsp1_valid  <= 1'b0;
         rsp1_result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  winner <= grant;
                  a_q    <= sel_a;
                  b_q    <= sel_b;
                  op_q   <= sel_op;
                  cnt    <= '0;
                  if (sel_op > OP_NE) begin
                     res   <= 1'b0;
                     state <= RESP;
                  end else begin
                     cmp_a <= sel_swap ? sel_b : sel_a;
                     cmp_b <= sel_swap ? sel_a : sel_b;
                     state <= PASS1;
                  end
               end
            end
            PASS1: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (two_pass) begin
                     g1    <= g;
                     cmp_a <= b_q;
                     cmp_b <= a_q;
                     state <= PASS2;
                  end else begin
                     res   <= g ^ invert;
                     cmp_a <= '0;
                     cmp_b <= '0;
                     state <= RESP;
                  end
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            PASS2: begin
               if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  res   <= (op_q == OP_EQ) ? (~g1 & ~g) : (g1 | g);
                  cmp_a <= '0;
                  cmp_b <= '0;
                  state <= RESP;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            RESP: begin
               // First RESP cycle raises the response; it then waits for ready.
               if (!rsp0_valid && !rsp1_valid) begin
                  if (winner) begin
                     rsp1_valid  <= 1'b1;
                     rsp1_result <= {{(WIDTH-1){1'b0}}, res};
                  end else begin
                     rsp0_valid  <= 1'b1;
                     rsp0_result <= {{(WIDTH-1){1'b0}}, res};
                  end
               end else if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                  rsp0_valid  <= 1'b0;
                  rsp0_result <= '0;
                  rsp1_valid  <= 1'b0;
                  rsp1_result <= '0;
                  rr_ptr      <= ~winner;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sched.sv
// Directed bench for cmp_sched with CMP_LAT=1 and a behavioural signed
// comparator driving cmp_g.
module tb_cmp_sched;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]   req0_op = '0, req1_op = '0;
   logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [W-1:0] rsp0_result, rsp1_result, cmp_a, cmp_b, cmp_g;

   int n_vec = 0;
   int n_err = 0;

   cmp_sched #(.WIDTH(W), .CMP_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
      .req0_b(req0_b), .req0_op(req0_op),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
      .req1_b(req1_b), .req1_op(req1_op),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
      .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_g(cmp_g)
   );

   always #5 clk = ~clk;

   assign cmp_g = {{(W-1){1'b0}}, ($signed(cmp_a) > $signed(cmp_b))};

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int id);
      return (id == 0) ? req0_ready : req1_ready;
   endfunction

   function automatic logic rv(input int id);
      return (id == 0) ? rsp0_valid : rsp1_valid;
   endfunction

   function automatic logic [W-1:0] rr(input int id);
      return (id == 0) ? rsp0_result : rsp1_result;
   endfunction

   task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op);
      if (id == 0) begin
         req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      end
   endtask

   // Waits (bounded) for ready, then takes the accept edge and drops valid.
   task automatic accept(input int id, input string tag, output int waited);
      waited = 0;
      #1;
      while (!rdy(id) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!rdy(id)) begin
         check({tag, "_accept_timeout"}, 0, 1);
      end else begin
         @(posedge clk);
         #1;
         if (id == 0) req0_valid = 1'b0;
         else         req1_valid = 1'b0;
      end
   endtask

   task automatic wait_rsp(input int id, input int lat, input logic res,
                           input logic [W-1:0] ca1, input logic [W-1:0] cb1,
                           input string tag);
      int k = 0;
      logic [W-1:0] sa = '1, sb = '1;
      while (!rv(id) && k < 20) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1) begin
            sa = cmp_a;
            sb = cmp_b;
         end
      end
      check({tag, "_latency"}, W'(k), W'(lat));
      check({tag, "_result"}, rr(id), {{(W-1){1'b0}}, res});
      check({tag, "_cmp_a_cyc1"}, sa, ca1);
      check({tag, "_cmp_b_cyc1"}, sb, cb1);
   endtask

   task automatic handshake(input int id, input string tag);
      if (id == 0) rsp0_ready = 1'b1;
      else         rsp1_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      check({tag, "_valid_clear"}, W'(rv(id)), 0);
   endtask

   // Full single-requester transaction with pass-1 and cycle-1 operand checks.
   task automatic run(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] op, input logic res, input int lat,
                      input logic [W-1:0] pa, input logic [W-1:0] pb,
                      input logic [W-1:0] ca1, input logic [W-1:0] cb1, input string tag);
      int w;
      @(negedge clk);
      set_req(id, a, b, op);
      accept(id, tag, w);
      check({tag, "_pass1_a"}, cmp_a, pa);
      check({tag, "_pass1_b"}, cmp_b, pb);
      wait_rsp(id, lat, res, ca1, cb1, tag);
      handshake(id, tag);
   endtask

   initial begin
      int w;
      // Reset state
      #12;
      check("rst_req0_ready", W'(req0_ready), 0);
      check("rst_rsp0_valid", W'(rsp0_valid), 0);
      check("rst_rsp1_valid", W'(rsp1_valid), 0);
      check("rst_cmp_a", cmp_a, 0);
      check("rst_cmp_b", cmp_b, 0);
      @(negedge clk);
      rst = 1'b0;

      run(0, 5, 3, 3'd0, 1'b1, 2, 5, 3, 0, 0, "gt_5_3");
      run(0, 32'hFFFFFFFF, 1, 3'd0, 1'b0, 2, 32'hFFFFFFFF, 1, 0, 0, "gt_neg");
      run(0, 32'hFFFFFFFF, 1, 3'd1, 1'b1, 2, 1, 32'hFFFFFFFF, 0, 0, "lt_neg");
      run(0, 32'hFFFFFFFF, 1, 3'd2, 1'b0, 2, 1, 32'hFFFFFFFF, 0, 0, "ge_neg");
      run(0, 32'hFFFFFFFF, 1, 3'd3, 1'b1, 2, 32'hFFFFFFFF, 1, 0, 0, "le_neg");
      run(0, 32'h1234, 32'h1234, 3'd4, 1'b1, 3, 32'h1234, 32'h1234, 32'h1234, 32'h1234, "eq_same");
      run(1, 7, 8, 3'd5, 1'b1, 3, 7, 8, 8, 7, "ne_7_8");
      run(1, 7, 8, 3'd4, 1'b0, 3, 7, 8, 8, 7, "eq_7_8");

      // Contention: rr_ptr is back at 0 after requester 1 was served.
      for (int round = 0; round < 2; round++) begin
         @(negedge clk);
         set_req(0, 1, 2, 3'd0);
         set_req(1, 1, 2, 3'd1);
         #1;
         check("cont_req0_first", W'(req0_ready), 1);
         check("cont_req1_blocked", W'(req1_ready), 0);
         accept(0, "cont0", w);
         check("cont_req1_busy", W'(req1_ready), 0);
         wait_rsp(0, 2, 1'b0, 0, 0, "cont0");
         handshake(0, "cont0");
         check("cont_req1_next", W'(req1_ready), 1);
         accept(1, "cont1", w);
         check("cont1_wait", W'(w), 0);
         wait_rsp(1, 2, 1'b1, 0, 0, "cont1");
         handshake(1, "cont1");
      end

      // Backpressure on requester 1 while requester 0 waits.
      @(negedge clk);
      set_req(1, 9, 2, 3'd0);
      accept(1, "bp1", w);
      wait_rsp(1, 2, 1'b1, 0, 0, "bp1");
      set_req(0, 4, 4, 3'd2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_rsp1_valid", W'(rsp1_valid), 1);
         check("bp_rsp1_result", rsp1_result, 1);
         check("bp_req0_ready", W'(req0_ready), 0);
      end
      handshake(1, "bp1");
      check("bp_req0_ready_after", W'(req0_ready), 1);
      accept(0, "bp0", w);
      check("bp0_wait", W'(w), 0);
      wait_rsp(0, 2, 1'b1, 0, 0, "bp0");
      handshake(0, "bp0");

      // Illegal op: no comparator pass.
      run(0, 3, 1, 3'd6, 1'b0, 1, 0, 0, 0, 0, "illegal6");

      // Reset in the middle of the second EQ pass.
      @(negedge clk);
      set_req(0, 5, 5, 3'd4);
      accept(0, "rst_eq", w);
      @(posedge clk);
      #1;
      check("rst_eq_in_pass2_a", cmp_a, 5);
      rst = 1'b1;
      #1;
      check("midrst_cmp_a", cmp_a, 0);
      check("midrst_cmp_b", cmp_b, 0);
      check("midrst_rsp0_valid", W'(rsp0_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("midrst_no_rsp", W'(rsp0_valid | rsp1_valid), 0);
      end
      run(0, 2, 1, 3'd0, 1'b1, 2, 2, 1, 0, 0, "post_rst_gt");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1, "watchdog");
   end
endmodule
